sram_1rw_pipe: RTL and testbench

SRAM_1RW_PIPE -- requirements
Module: sram_1rw_pipe

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_1rw_array.sv | 90 +++++++++
 rtl/sram_1rw_pipe.sv | 109 ++++++++++
 tb/tb_sram_1rw_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults, lane-count helper and response entry type for
// the sram_1rw_pipe block and its storage array.
package sram_pkg;

    localparam int SRAM_WIDTH  = 46;
    localparam int SRAM_DEPTH  = 128;
    localparam int SRAM_LANE_W = 8;

    // Number of write-mask lanes; the top lane is narrower when lane_w does
    // not divide width evenly.
    function automatic int lane_count(input int width, input int lane_w);
        return (width + lane_w - 1) / lane_w;
    endfunction

    // One buffered read response. Sized for the default word width; the
    // pipe resizes its data into and out of this container.
    typedef struct packed {
        logic [SRAM_WIDTH-1:0] rdata;
        logic                  perr;
    } rsp_entry_t;

endpackage

// File: rtl/sram_1rw_array.sv
// sram_1rw_array: word storage with per-lane masked write and a registered
// read port. Out-of-range addresses (non power-of-two DEPTH) write nothing
// and read zero. Define SRAM_PARITY_EN to keep one even-parity bit per lane
// and flag mismatches on read.
module sram_1rw_array
    import sram_pkg::*;
#(
    parameter int  WIDTH  = SRAM_WIDTH,
    parameter int  DEPTH  = SRAM_DEPTH,
    parameter int  LANE_W = SRAM_LANE_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int ML     = lane_count(WIDTH, LANE_W)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ML-1:0]    mask_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             perr_o
);

    logic             in_range;
    logic [WIDTH-1:0] bit_en;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    if (DEPTH == (1 << AW)) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = (32'(addr_i) < DEPTH);
    end

    // Spread the lane mask to one enable per data bit.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit_en
        assign bit_en[b] = mask_i[b / LANE_W];
    end

    // Masked write: only bits of enabled lanes change.
    // NOTE: the storage and its read register have no reset; contents are
    // undefined until written, which is what a real macro does.
    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            mem[addr_i] <= (mem[addr_i] & ~bit_en) | (wdata_i & bit_en);
        end
    end

    // Registered read; out-of-range addresses return zero.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= in_range ? mem[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

`ifdef SRAM_PARITY_EN
    logic [ML-1:0] par_mem [DEPTH];
    logic [ML-1:0] par_q;
    logic [ML-1:0] wpar;
    logic [ML-1:0] rpar;

    for (genvar l = 0; l < ML; l++) begin : g_lane_par
        localparam int LO = l * LANE_W;
        localparam int HI = (LO + LANE_W > WIDTH) ? WIDTH - 1 : LO + LANE_W - 1;
        assign wpar[l] = ^wdata_i[HI:LO];
        assign rpar[l] = ^rdata_q[HI:LO];
    end

    // Parity bits follow their lanes: recomputed only where the mask is set.
    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            par_mem[addr_i] <= (par_mem[addr_i] & ~mask_i) | (wpar & mask_i);
        end
    end

    // Stored parity captured alongside the read data.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            par_q <= in_range ? par_mem[addr_i] : '0;
        end
    end

    assign perr_o = |(rpar ^ par_q);
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/sram_1rw_pipe.sv
// sram_1rw_pipe: single-port SRAM with valid/ready request and response
// channels. Reads return one cycle after acceptance through a 2-entry
// response FIFO; req_ready depends on registered occupancy only.
// Optional per-lane parity is enabled with SRAM_PARITY_EN.
module sram_1rw_pipe
    import sram_pkg::*;
#(
    parameter int  WIDTH  = SRAM_WIDTH,
    parameter int  DEPTH  = SRAM_DEPTH,
    parameter int  LANE_W = SRAM_LANE_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int ML     = lane_count(WIDTH, LANE_W)
) (
    input  logic             CE,
    input  logic             RSTB,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [ML-1:0]    req_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_perr
);

    logic             accept;
    logic             rd_acc;
    logic             wr_acc;
    logic             push;
    logic             pop;
    logic             rd_inflight_q;
    logic [1:0]       fifo_count_q;
    logic [1:0]       fifo_count_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    rsp_entry_t       fifo_q [2];
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic [WIDTH-1:0] arr_rdata;
    logic             arr_perr;

    // Room for a new read exists only if buffered plus in-flight is below 2.
    assign req_ready = (3'(fifo_count_q) + 3'(rd_inflight_q)) < 3'd2;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign wr_acc    = accept && req_we;

    sram_1rw_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .LANE_W (LANE_W)
    ) u_array (
        .clk_i   (CE),
        .we_i    (wr_acc),
        .re_i    (rd_acc),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .mask_i  (req_mask),
        .rdata_o (arr_rdata),
        .perr_o  (arr_perr)
    );

    assign push       = rd_inflight_q;
    assign pop        = rsp_valid && rsp_ready;
    assign push_entry = '{rdata: SRAM_WIDTH'(arr_rdata), perr: arr_perr};
    assign head       = fifo_q[rd_ptr_q];
    assign rsp_valid  = (fifo_count_q != 2'd0);
    assign rsp_rdata  = WIDTH'(head.rdata);
    assign rsp_perr   = head.perr;

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    // NOTE: every signal written in always_comb gets a default first, so no
    // latch can be inferred on an uncovered path.
    always_comb begin
        fifo_count_d = fifo_count_q;
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + 2'd1;
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - 2'd1;
        end
    end

    // In-flight flag, FIFO pointers and entries; reset discards everything.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            rd_inflight_q <= 1'b0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
        end else begin
            rd_inflight_q <= rd_acc;
            fifo_count_q  <= fifo_count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_pipe.sv
// Testbench for sram_1rw_pipe: scoreboard of expected read responses,
// reference memory model, backpressure, burst, reset and range scenarios.
module tb_sram_1rw_pipe;

    localparam int WIDTH  = 46;
    localparam int DEPTH  = 128;
    localparam int LANE_W = 8;
    localparam int AW     = 7;
    localparam int ML     = (WIDTH + LANE_W - 1) / LANE_W;
    localparam logic [WIDTH-1:0] LANE_ONES = WIDTH'({LANE_W{1'b1}});

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             perr;
    } exp_t;

    logic             CE;
    logic             RSTB;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [ML-1:0]    req_mask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_perr;

    // Second instance with non power-of-two depth for out-of-range accesses.
    logic             b_req_valid;
    logic             b_req_ready;
    logic             b_req_we;
    logic [AW-1:0]    b_req_addr;
    logic [WIDTH-1:0] b_req_wdata;
    logic             b_rsp_valid;
    logic [WIDTH-1:0] b_rsp_rdata;
    logic             b_rsp_perr;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_rsp   = 0;
    exp_t             sb_q[$];
    exp_t             sb_head;
    logic [WIDTH-1:0] model [DEPTH];

    sram_1rw_pipe dut (
        .CE        (CE),
        .RSTB      (RSTB),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr)
    );

    sram_1rw_pipe #(.DEPTH(100)) dut2 (
        .CE        (CE),
        .RSTB      (RSTB),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (b_req_we),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .req_mask  ({ML{1'b1}}),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (1'b1),
        .rsp_rdata (b_rsp_rdata),
        .rsp_perr  (b_rsp_perr)
    );

    initial CE = 1'b0;
    always #5 CE = ~CE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] expand(input logic [ML-1:0] mask);
        logic [WIDTH-1:0] m  = '0;
        logic [ML-1:0]    mk = mask;
        for (int l = 0; l < ML; l++) begin
            if (mk[0]) m = m | (LANE_ONES << (l * LANE_W));
            mk = mk >> 1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        return WIDTH'({$urandom(), $urandom()});
    endfunction

    // Idle request bus carries a harmless-looking write to addr 5 with
    // valid low; it must never take effect.
    task automatic idle_bus();
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = AW'(5);
        req_wdata = rnd_word();
        req_mask  = '1;
    endtask

    // Drive one request, hold it until accepted, update model/scoreboard.
    // Called and returns just after a rising edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] data, input logic [ML-1:0] mask);
        int w = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_mask  = mask;
        @(negedge CE);
        while (!req_ready && w < 50) begin
            w++;
            @(negedge CE);
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1);
        @(posedge CE);
        #1;
        if (we) begin
            model[addr] = (model[addr] & ~expand(mask)) | (data & expand(mask));
        end else begin
            sb_q.push_back('{data: model[addr], perr: 1'b0});
        end
        idle_bus();
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge CE);
            w++;
        end
        check("drain_done", 64'(sb_q.size()), 0);
        @(posedge CE);
        #1;
    endtask

    // Response monitor: each handshake is compared against the scoreboard.
    always @(negedge CE) begin
        if (RSTB && rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_head = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, sb_head.data);
                check("rsp_perr", rsp_perr, sb_head.perr);
            end
            n_rsp++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               rsp_before;
        int               w;
        logic [WIDTH-1:0] d;

        RSTB        = 1'b0;
        rsp_ready   = 1'b1;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        idle_bus();

        // Reset state.
        repeat (3) @(negedge CE);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_perr", rsp_perr, 0);
        RSTB = 1'b1;
        @(negedge CE);
        check("rst_req_ready", req_ready, 1);
        @(posedge CE);
        #1;

        // Full write then read with latency check.
        issue(1'b1, AW'(5), 46'h1234_5678_9AB, '1);
        issue(1'b0, AW'(5), '0, '0);
        check("lat_edge_t", rsp_valid, 0);
        @(posedge CE);
        #1;
        check("lat_edge_t1", rsp_valid, 1);
        check("lat_rdata", rsp_rdata, 46'h1234_5678_9AB);
        drain();

        // Masked overwrite of the low lane only.
        issue(1'b1, AW'(7), '1, '1);
        issue(1'b1, AW'(7), '0, 6'b000001);
        issue(1'b0, AW'(7), '0, '0);
        @(posedge CE);
        #1;
        check("mask_low_lane", rsp_rdata, 46'h3FFF_FFFF_FF00);
        drain();

        // Read right after a write to the same address.
        issue(1'b1, AW'(9), 46'h2AAA_5555_1234, '1);
        issue(1'b0, AW'(9), '0, '0);
        drain();

        // Random masked writes, including the partial top lane.
        for (int a = 20; a < 24; a++) issue(1'b1, AW'(a), rnd_word(), '1);
        issue(1'b1, AW'(21), rnd_word(), 6'b100000);
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, AW'($urandom_range(20, 23)), rnd_word(), ML'($urandom_range(0, 63)));
        end
        for (int a = 20; a < 24; a++) issue(1'b0, AW'(a), '0, '0);
        drain();

        // Backpressure: third read must wait while the response side stalls.
        rsp_ready  = 1'b0;
        rsp_before = n_rsp;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = AW'(5);
        @(negedge CE);
        check("bp_ready_first", req_ready, 1);
        @(posedge CE);
        #1;
        sb_q.push_back('{data: model[5], perr: 1'b0});
        req_addr = AW'(7);
        @(negedge CE);
        check("bp_ready_second", req_ready, 1);
        @(posedge CE);
        #1;
        sb_q.push_back('{data: model[7], perr: 1'b0});
        req_addr = AW'(9);
        for (int c = 0; c < 4; c++) begin
            @(negedge CE);
            check("bp_ready_low", req_ready, 0);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_rdata_stable", rsp_rdata, model[5]);
        end
        @(posedge CE);
        #1;
        rsp_ready = 1'b1;
        w = 0;
        @(negedge CE);
        while (!req_ready && w < 20) begin
            w++;
            @(negedge CE);
        end
        check("bp_third_ready", req_ready, 1);
        @(posedge CE);
        #1;
        sb_q.push_back('{data: model[9], perr: 1'b0});
        idle_bus();
        drain();
        check("bp_rsp_count", 64'(n_rsp - rsp_before), 3);

        // Burst of 16 reads with the response side always ready.
        for (int a = 0; a < 16; a++) issue(1'b1, AW'(a), rnd_word(), '1);
        rsp_before = n_rsp;
        for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, '0);
        drain();
        check("burst_rsp_count", 64'(n_rsp - rsp_before), 16);

        // Reset one cycle after a read accept discards the response.
        issue(1'b0, AW'(5), '0, '0);
        RSTB = 1'b0;
        sb_q.delete();
        rsp_before = n_rsp;
        repeat (3) begin
            @(negedge CE);
            check("midrst_valid", rsp_valid, 0);
            check("midrst_rdata", rsp_rdata, 0);
        end
        RSTB = 1'b1;
        repeat (4) begin
            @(negedge CE);
            check("postrst_valid", rsp_valid, 0);
        end
        check("postrst_ready", req_ready, 1);
        check("postrst_no_rsp", 64'(n_rsp - rsp_before), 0);
        @(posedge CE);
        #1;

        // Out-of-range on the 100-word instance; addr 99 is the last word.
        d = rnd_word();
        check("b_ready_idle", b_req_ready, 1);
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = AW'(110);
        b_req_wdata = '1;
        @(posedge CE);
        #1;
        b_req_addr  = AW'(99);
        b_req_wdata = d;
        @(posedge CE);
        #1;
        b_req_we   = 1'b0;
        b_req_addr = AW'(110);
        @(posedge CE);
        #1;
        b_req_addr = AW'(99);
        @(posedge CE);
        #1;
        b_req_valid = 1'b0;
        check("oor_valid", b_rsp_valid, 1);
        check("oor_rdata", b_rsp_rdata, 0);
        check("oor_perr", b_rsp_perr, 0);
        @(posedge CE);
        #1;
        check("lastword_valid", b_rsp_valid, 1);
        check("lastword_rdata", b_rsp_rdata, d);

`ifdef SRAM_PARITY_EN
        // Corrupt one stored bit and expect the parity flag with that response.
        issue(1'b1, AW'(3), 46'h0ABC_DEF0_1234, '1);
        issue(1'b1, AW'(4), 46'h1111_2222_3333, '1);
        dut.u_array.mem[3][9] = ~dut.u_array.mem[3][9];
        d = 46'h0ABC_DEF0_1234 ^ 46'h200;
        issue(1'b0, AW'(3), '0, '0);
        void'(sb_q.pop_back());
        sb_q.push_back('{data: d, perr: 1'b1});
        issue(1'b0, AW'(4), '0, '0);
        drain();
`endif

        repeat (2) @(posedge CE);
        check("sb_empty", 64'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
